// File: rtl/l1_mmu_arbiter.sv
// rtl/l1_mmu_arbiter.sv - round-robin arbiter sharing one MMU port between L1 I-cache and D-cache
`timescale 1ns/1ps
module l1_mmu_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              ic_req_read,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_done,
  input  logic              dc_req_read,
  input  logic              dc_req_write,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_done,
  output logic [LINE_W-1:0] l1_read_data,
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_req_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic              grant_dc,
  output logic              err_timeout,
  output logic              err_spurious_done
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_GAP} state_t;

  state_t          r_state;
  logic            r_last_dc;
  logic [WD_W-1:0] r_wd;
  logic            r_err_timeout;
  logic            r_err_spurious;

  logic            w_ic_act;
  logic            w_dc_act;
  logic [WD_W-1:0] w_wd_next;

  assign w_ic_act  = ic_req_read;
  assign w_dc_act  = dc_req_read | dc_req_write;
  assign w_wd_next = (r_wd == WD_MAX) ? r_wd : r_wd + WD_W'(1);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_last_dc      <= 1'b0;
      r_wd           <= '0;
      r_err_timeout  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wd <= '0;
          if (mmu_done) r_err_spurious <= 1'b1;
          if (w_ic_act && w_dc_act) r_state <= r_last_dc ? S_BUSY_I : S_BUSY_D;
          else if (w_ic_act)        r_state <= S_BUSY_I;
          else if (w_dc_act)        r_state <= S_BUSY_D;
        end
        S_BUSY_I, S_BUSY_D: begin
          if (mmu_done) begin
            r_last_dc <= (r_state == S_BUSY_D);
            r_state   <= S_GAP;
          end else begin
            // watchdog only observes; the grant is never revoked
            r_wd <= w_wd_next;
            if (TIMEOUT != 0 && w_wd_next == WD_MAX) r_err_timeout <= 1'b1;
          end
        end
        S_GAP: begin
          if (mmu_done) r_err_spurious <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // select comes from registered state only, so the mux cannot glitch on unselected inputs
  always_comb begin
    mmu_req_read   = 1'b0;
    mmu_req_write  = 1'b0;
    mmu_req_addr   = '0;
    mmu_write_data = '0;
    ic_done        = 1'b0;
    dc_done        = 1'b0;
    case (r_state)
      S_BUSY_I: begin
        mmu_req_read = ic_req_read;
        mmu_req_addr = ic_req_addr;
        ic_done      = mmu_done;
      end
      S_BUSY_D: begin
        mmu_req_read   = dc_req_read;
        mmu_req_write  = dc_req_write;
        mmu_req_addr   = dc_req_addr;
        mmu_write_data = dc_write_data;
        dc_done        = mmu_done;
      end
      default: ;
    endcase
  end

  assign grant_dc          = (r_state == S_BUSY_D);
  assign l1_read_data      = mmu_read_data;
  assign err_timeout       = r_err_timeout;
  assign err_spurious_done = r_err_spurious;

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// tb/tb_l1_mmu_arbiter.sv - directed plus randomized bench for l1_mmu_arbiter against a round-robin model
`timescale 1ns/1ps
module tb_l1_mmu_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;

  logic          sys_clk;
  logic          rst;
  logic          ic_req_read;
  logic [AW-1:0] ic_req_addr;
  logic          ic_done;
  logic          dc_req_read;
  logic          dc_req_write;
  logic [AW-1:0] dc_req_addr;
  logic [LW-1:0] dc_write_data;
  logic          dc_done;
  logic [LW-1:0] l1_read_data;
  logic          mmu_req_read;
  logic          mmu_req_write;
  logic [AW-1:0] mmu_req_addr;
  logic [LW-1:0] mmu_write_data;
  logic          mmu_done;
  logic [LW-1:0] mmu_read_data;
  logic          grant_dc;
  logic          err_timeout;
  logic          err_spurious_done;

  int ntests = 0;
  int nfail  = 0;

  bit last_dc;
  bit exp_to;
  bit exp_sp;

  l1_mmu_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .ic_req_read(ic_req_read), .ic_req_addr(ic_req_addr), .ic_done(ic_done),
    .dc_req_read(dc_req_read), .dc_req_write(dc_req_write), .dc_req_addr(dc_req_addr),
    .dc_write_data(dc_write_data), .dc_done(dc_done), .l1_read_data(l1_read_data),
    .mmu_req_read(mmu_req_read), .mmu_req_write(mmu_req_write), .mmu_req_addr(mmu_req_addr),
    .mmu_write_data(mmu_write_data), .mmu_done(mmu_done), .mmu_read_data(mmu_read_data),
    .grant_dc(grant_dc), .err_timeout(err_timeout), .err_spurious_done(err_spurious_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick();
    bit dc_act;
    dc_act = dc_req_read | dc_req_write;
    if (ic_req_read && dc_act) return !last_dc;
    return dc_act;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Entered at an IDLE negedge with the winner's request held; returns at the following IDLE negedge.
  task automatic serve(input bit who, input int d, input logic [LW-1:0] rd);
    logic          er;
    logic          ew;
    logic [AW-1:0] ea;
    logic [LW-1:0] ewd;
    #1;
    chk("idle_req", 256'({mmu_req_read, mmu_req_write}), 256'(0));
    @(negedge sys_clk);
    er  = who ? dc_req_read   : ic_req_read;
    ew  = who ? dc_req_write  : 1'b0;
    ea  = who ? dc_req_addr   : ic_req_addr;
    ewd = who ? dc_write_data : '0;
    chk("grant_dc", 256'(grant_dc), 256'(who));
    chk("busy_req", 256'({mmu_req_read, mmu_req_write, mmu_req_addr}), 256'({er, ew, ea}));
    chk("busy_wdata", 256'(mmu_write_data), 256'(ewd));
    for (int i = 1; i <= d; i++) begin
      @(negedge sys_clk);
      if (i >= TO) exp_to = 1'b1;
      chk("hold_req", 256'({mmu_req_read, mmu_req_write, mmu_req_addr, grant_dc}), 256'({er, ew, ea, who}));
      chk("watchdog", 256'(err_timeout), 256'(exp_to));
    end
    mmu_done = 1'b1;
    mmu_read_data = rd;
    #1;
    chk("done", 256'({ic_done, dc_done}), 256'(who ? 2'b01 : 2'b10));
    chk("rdata", 256'(l1_read_data), 256'(rd));
    @(negedge sys_clk);
    mmu_done = 1'b0;
    if (who) begin
      dc_req_read = 1'b0;
      dc_req_write = 1'b0;
    end else begin
      ic_req_read = 1'b0;
    end
    chk("gap_req", 256'({mmu_req_read, mmu_req_write, mmu_req_addr, ic_done, dc_done, grant_dc}), 256'(0));
    chk("gap_wdata", 256'(mmu_write_data), 256'(0));
    chk("gap_err", 256'({err_timeout, err_spurious_done}), 256'({exp_to, exp_sp}));
    @(negedge sys_clk);
    chk("idle_after", 256'({mmu_req_read, mmu_req_write, mmu_req_addr, grant_dc}), 256'(0));
    last_dc = who;
  endtask

  task automatic run_round();
    int guard;
    guard = 0;
    while ((ic_req_read || dc_req_read || dc_req_write) && guard < 4) begin
      serve(pick(), $urandom_range(0, 5), rnd_line());
      guard++;
    end
  endtask

  initial begin
    rst = 1'b1;
    ic_req_read = 1'b0; ic_req_addr = '0;
    dc_req_read = 1'b0; dc_req_write = 1'b0; dc_req_addr = '0; dc_write_data = '0;
    mmu_done = 1'b0; mmu_read_data = '0;
    last_dc = 1'b0; exp_to = 1'b0; exp_sp = 1'b0;
    #3;
    chk("reset_out", 256'({mmu_req_read, mmu_req_write, ic_done, dc_done, grant_dc, err_timeout, err_spurious_done}), 256'(0));
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;

    // lone I-cache fetch, done after 5 cycles
    @(negedge sys_clk);
    ic_req_read = 1'b1; ic_req_addr = 32'h0000_1000;
    serve(1'b0, 5, {32{8'hAB}});

    // two simultaneous rounds from last_grant=I: D first each time
    ic_req_read = 1'b1; ic_req_addr = $urandom;
    dc_req_read = 1'b1; dc_req_addr = $urandom;
    chk("pick_first_d", 256'(pick()), 256'(1));
    run_round();
    ic_req_read = 1'b1; ic_req_addr = $urandom;
    dc_req_read = 1'b1; dc_req_addr = $urandom;
    chk("pick_alt_d", 256'(pick()), 256'(1));
    run_round();

    // write-back, I-cache waiting, then refill
    ic_req_read = 1'b1; ic_req_addr = 32'h0000_2000;
    dc_req_write = 1'b1; dc_req_addr = 32'h0040_0020; dc_write_data = {8{32'h1234_5678}};
    serve(pick(), 3, rnd_line());
    dc_req_read = 1'b1; dc_req_addr = 32'h0040_0020; dc_write_data = '0;
    chk("refill_loses", 256'(pick()), 256'(0));
    run_round();

    for (int r = 0; r < 24; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      ic_req_read = sel[0]; ic_req_addr = $urandom;
      if (sel[1]) begin
        if ($urandom_range(0, 1) == 1) dc_req_write = 1'b1;
        else dc_req_read = 1'b1;
      end
      dc_req_addr = $urandom; dc_write_data = rnd_line();
      run_round();
      chk("round_drained", 256'({ic_req_read, dc_req_read, dc_req_write}), 256'(0));
    end

    // watchdog: I-cache waits past TIMEOUT, grant held, flag stays after done
    ic_req_read = 1'b1; ic_req_addr = $urandom;
    serve(1'b0, TO + 3, rnd_line());
    chk("timeout_sticky", 256'(err_timeout), 256'(1));

    // spurious done in IDLE
    mmu_done = 1'b1;
    #1;
    chk("spur_no_fwd", 256'({ic_done, dc_done}), 256'(0));
    @(negedge sys_clk);
    mmu_done = 1'b0;
    exp_sp = 1'b1;
    chk("spur_flag", 256'(err_spurious_done), 256'(1));

    // asynchronous reset in BUSY_D
    dc_req_read = 1'b1; dc_req_addr = $urandom;
    @(negedge sys_clk);
    chk("pre_rst_grant", 256'(grant_dc), 256'(1));
    mmu_done = 1'b1;
    #1;
    chk("pre_rst_done", 256'(dc_done), 256'(1));
    #1 rst = 1'b1;
    #1;
    chk("async_rst", 256'({mmu_req_read, mmu_req_write, mmu_req_addr, ic_done, dc_done, grant_dc, err_timeout, err_spurious_done}), 256'(0));
    mmu_done = 1'b0; dc_req_read = 1'b0;
    @(negedge sys_clk);
    rst = 1'b0;
    last_dc = 1'b0; exp_to = 1'b0; exp_sp = 1'b0;
    ic_req_read = 1'b1; ic_req_addr = $urandom;
    dc_req_read = 1'b1; dc_req_addr = $urandom;
    chk("post_rst_pick", 256'(pick()), 256'(1));
    run_round();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/l1_mmu_arbiter.md
Name: l1_mmu_arbiter

Overview:
Shares the single MMU port between the L1 instruction cache and the L1 data cache. Arbitration is round-robin with the grant held for one complete transaction. It sits between both L1 caches and the MMU and forwards requests, done pulses and read data. It also supervises the port with a busy watchdog and a spurious-done detector.

Parameters:
ADDR_W, 32, request address width.
LINE_W, 256, cache-line / write-data width.
TIMEOUT, 1023, max cycles a grant may wait for mmu_done before timeout is flagged; 0 disables the watchdog.

Ports:
sys_clk  in  1  clock
rst  in  1  asynchronous active-high reset
ic_req_read  in  1  I-cache line fetch request (level, held until ic_done)
ic_req_addr  in  ADDR_W  I-cache request address
ic_done  out  1  one-cycle completion pulse to I-cache
dc_req_read  in  1  D-cache read request (level)
dc_req_write  in  1  D-cache write request (level)
dc_req_addr  in  ADDR_W  D-cache request address
dc_write_data  in  LINE_W  D-cache write data
dc_done  out  1  one-cycle completion pulse to D-cache
l1_read_data  out  LINE_W  MMU read data, broadcast to both caches
mmu_req_read  out  1  read request to MMU
mmu_req_write  out  1  write request to MMU
mmu_req_addr  out  ADDR_W  address to MMU
mmu_write_data  out  LINE_W  write data to MMU
mmu_done  in  1  MMU completion pulse
mmu_read_data  in  LINE_W  MMU read data
grant_dc  out  1  1 while the D-cache owns the port (debug)
err_timeout  out  1  sticky: watchdog expired
err_spurious_done  out  1  sticky: mmu_done seen with no grant

Behaviour:
- Reset is asynchronous active-high and takes effect immediately. Reset values: state=IDLE, last_grant=I-cache, watchdog=0, err_timeout=0, err_spurious_done=0. While in reset all mmu_req_*=0, ic_done=0, dc_done=0 and grant_dc=0.
- Requesters assert requests as levels and hold them until their done pulse. dc_req_read and dc_req_write are never asserted together; if both are asserted, forward both unchanged (the MMU's concern).
- States are IDLE, BUSY_I, BUSY_D and GAP.
- IDLE:
  - Drive all mmu_req_*=0.
  - If only one requester is active, grant it.
  - If both are active, grant the one that is not last_grant.
  - The transition happens on the next posedge, so arbitration costs 1 cycle of latency from a request to mmu_req_*.
- BUSY_x:
  - Drive mmu_req_read, mmu_req_write, mmu_req_addr and mmu_write_data combinationally from the granted requester's live inputs. The I-cache drives mmu_req_write=0 and mmu_write_data=0.
  - The non-granted mux inputs are don't-care and must not glitch the outputs.
  - On mmu_done=1, assert the granted requester's done in the same cycle (combinational), set last_grant=x and go to GAP.
  - The non-granted done output stays 0 at all times.
- GAP: exactly one cycle with mmu_req_*=0, so the MMU sees the request drop, then go to IDLE. A D-cache that issues a write-back followed by a refill re-arbitrates and may lose to a waiting I-cache.
- If the granted requester drops its request in BUSY without mmu_done, stay in BUSY; this is a protocol violation and is not recovered.
- l1_read_data = mmu_read_data at all times (pass-through).
- grant_dc=1 only in BUSY_D.
- Watchdog:
  - The counter clears when entering BUSY_x and increments every BUSY cycle without mmu_done.
  - When the count reaches TIMEOUT (TIMEOUT>0), set err_timeout (sticky).
  - The counter saturates and arbitration is unaffected.
- mmu_done=1 in IDLE or GAP sets err_spurious_done (sticky) and is not forwarded.
- Both sticky flags clear only on rst.
- Reset in mid-transaction returns to IDLE immediately and drops mmu_req_*. The MMU and requesters must also be reset.

Test Plan:
- Only the I-cache requests, ic_req_addr=0x0000_1000. mmu_req_read rises 1 cycle later with mmu_req_addr=0x1000. MMU pulses done after 5 cycles with data 0xAB..AB. ic_done pulses in that same cycle, l1_read_data=0xAB..AB, dc_done stays 0, and the next cycle is GAP with mmu_req_read=0.
- Both request in the same cycle after reset (last_grant=I). D-cache is granted first and grant_dc=1. After its done and the GAP cycle, the I-cache is granted. A second simultaneous round alternates back to D-cache.
- D-cache write-back at 0x0040_0020 with write data 0x1234..., then a refill read. mmu_req_write=1 and mmu_write_data match the input. After dc_done there is one GAP cycle with requests 0, then mmu_req_read=1. With the I-cache also waiting, the I-cache is served between the write-back and the refill.
- TIMEOUT=8, grant I-cache, mmu_done never arrives. err_timeout=1 after 8 BUSY cycles and the grant is still held. Then apply mmu_done: ic_done pulses and err_timeout stays 1.
- Pulse mmu_done in IDLE. err_spurious_done=1 and ic_done=dc_done=0.
- Assert rst during BUSY_D. All outputs are 0 immediately, without waiting for a clock edge. After release, the next request is arbitrated from IDLE with last_grant=I.
